// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: the RAM handshake state seen by the arbiter.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM among NREQ requesters,
// with bounded burst locking and a registered one-cycle arbitration bubble.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAXLOCK = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_ren,
    input  logic [NREQ-1:0]       req_wen,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ-1:0][31:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_store,
    output logic [NREQ-1:0]       req_wait,
    output logic [NREQ-1:0][31:0] req_load,
    output logic [NREQ-1:0]       grant,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate,
    output logic                  err
);

    localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            LW        = $clog2(MAXLOCK + 1);
    localparam logic [IW-1:0] LAST      = IW'(NREQ - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(MAXLOCK - 1);

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [LW-1:0]   r_lockcnt;

    logic [NREQ-1:0] w_req;
    logic            w_own_req;
    logic            w_burst_more;
    logic [IW-1:0]   w_next_ptr;
    logic [IW-1:0]   w_pick;
    logic [IW:0]     w_idx;

    assign w_req        = req_ren | req_wen;
    assign w_own_req    = w_req[r_owner];
    assign w_burst_more = req_lock[r_owner] && (r_lockcnt < LOCK_LAST);
    assign w_next_ptr   = (r_owner == LAST) ? '0 : r_owner + IW'(1);

    // Scan downward so the requester closest to r_ptr (smallest offset) wins.
    always_comb begin
        w_pick = r_ptr;
        w_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IW + 1)'(k);
            if (w_idx >= (IW + 1)'(NREQ)) begin
                w_idx = w_idx - (IW + 1)'(NREQ);
            end
            if (w_req[w_idx[IW-1:0]]) begin
                w_pick = w_idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ARB;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_lockcnt <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (|w_req) begin
                        r_owner   <= w_pick;
                        r_lockcnt <= '0;
                        r_state   <= OWN;
                    end
                end
                OWN: begin
                    // An abort or RAM error both hand the slot to the next port.
                    if (!w_own_req || ramstate == ERROR) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= ARB;
                    end else if (ramstate == ACCESS) begin
                        if (w_burst_more) begin
                            r_lockcnt <= r_lockcnt + LW'(1);
                        end else begin
                            r_ptr   <= w_next_ptr;
                            r_state <= ARB;
                        end
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // RAM side follows the owner combinationally; the arbiter never latches addr/data.
    always_comb begin
        grant    = '0;
        req_wait = '1;
        req_load = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        err      = 1'b0;
        if (r_state == OWN) begin
            grant[r_owner]    = 1'b1;
            req_load[r_owner] = ramload;
            if (w_own_req) begin
                ramWEN            = req_wen[r_owner];
                ramREN            = req_ren[r_owner] & ~req_wen[r_owner];
                ramaddr           = req_addr[r_owner];
                ramstore          = req_store[r_owner];
                req_wait[r_owner] = (ramstate != ACCESS);
                err               = (ramstate == ERROR);
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ    = 4;
    localparam int MAXLOCK = 8;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [3:0]      req_ren, req_wen, req_lock;
    logic [3:0][31:0] req_addr, req_store;
    logic [3:0]      req_wait;
    logic [3:0][31:0] req_load;
    logic [3:0]      grant;
    logic            ramREN, ramWEN;
    logic [31:0]     ramaddr, ramstore, ramload;
    ramstate_t       ramstate;
    logic            err;

    int checks = 0;
    int passed = 0;
    int acc_q[$];
    int cyc_q[$];
    logic [1:0] rw_q[$];
    logic [3:0] keep;

    ram_arbiter #(.NREQ(NREQ), .MAXLOCK(MAXLOCK)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load), .grant(grant),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic int idx_of(input logic [3:0] oh);
        for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [3:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        req_ren   = '0;
        req_wen   = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_store = '0;
        ramload   = '0;
        ramstate  = FREE;
        keep      = '0;
        acc_q.delete();
        cyc_q.delete();
        rw_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
    endtask

    // Acts as RAM: each granted, enabled access takes nbusy BUSY cycles then ACCESS.
    task automatic run(input int cycles, input int nbusy);
        int busy;
        int last;
        int g;
        busy = 0;
        last = -1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge CLK);
            #1;
            if (last >= 0 && !keep[last]) begin
                req_ren[last] = 1'b0;
                req_wen[last] = 1'b0;
            end
            last = -1;
            #1;
            g       = idx_of(grant);
            ramload = $urandom;
            if (g >= 0 && (ramREN || ramWEN)) begin
                if (busy < nbusy) begin
                    ramstate = BUSY;
                    busy++;
                end else begin
                    ramstate = ACCESS;
                    busy = 0;
                    acc_q.push_back(g);
                    cyc_q.push_back(c);
                    rw_q.push_back({ramREN, ramWEN});
                    last = g;
                end
            end else begin
                ramstate = FREE;
                busy = 0;
            end
        end
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        req_ren  = '1;
        req_wen  = '0;
        req_lock = '0;
        req_addr = '1;
        req_store = '1;
        ramload  = 32'hFFFF_FFFF;
        ramstate = ACCESS;
        tick();
        tick();
        checks++; if (grant !== 4'b0000) $display("FAIL reset_grant got %b exp 0000", grant); else passed++;
        checks++; if (req_wait !== 4'b1111) $display("FAIL reset_wait got %b exp 1111", req_wait); else passed++;
        checks++; if (req_load !== '0) $display("FAIL reset_load got %h exp 0", req_load); else passed++;
        checks++; if ({ramREN, ramWEN} !== 2'b00) $display("FAIL reset_en got %b exp 00", {ramREN, ramWEN}); else passed++;
        checks++; if ({ramaddr, ramstore} !== 64'h0) $display("FAIL reset_bus got %h exp 0", {ramaddr, ramstore}); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
    endtask

    task automatic test_single_read();
        do_reset();
        req_ren[2]  = 1'b1;
        req_addr[2] = 32'h40;
        #1;
        checks++; if (grant !== 4'b0000) $display("FAIL read_bubble got %b exp 0000", grant); else passed++;
        tick();
        ramstate = BUSY;
        #1;
        checks++; if (grant !== 4'b0100) $display("FAIL read_grant got %b exp 0100", grant); else passed++;
        checks++; if ({ramREN, ramWEN} !== 2'b10) $display("FAIL read_en got %b exp 10", {ramREN, ramWEN}); else passed++;
        checks++; if (ramaddr !== 32'h40) $display("FAIL read_addr got %h exp 40", ramaddr); else passed++;
        checks++; if (req_wait !== 4'b1111) $display("FAIL read_wait_busy got %b exp 1111", req_wait); else passed++;
        tick();
        #1;
        checks++; if (req_wait !== 4'b1111) $display("FAIL read_wait_busy2 got %b exp 1111", req_wait); else passed++;
        tick();
        ramstate = ACCESS;
        ramload  = 32'hDEAD_BEEF;
        #1;
        checks++; if (req_wait !== 4'b1011) $display("FAIL read_wait_access got %b exp 1011", req_wait); else passed++;
        checks++; if (req_load[2] !== 32'hDEAD_BEEF) $display("FAIL read_load got %h exp deadbeef", req_load[2]); else passed++;
        tick();
        req_ren  = 4'b1001;
        ramstate = FREE;
        #1;
        checks++; if (grant !== 4'b0000) $display("FAIL read_arb_after got %b exp 0000", grant); else passed++;
        tick();
        #1;
        checks++; if (grant !== 4'b1000) $display("FAIL read_ptr3 got %b exp 1000", grant); else passed++;
    endtask

    task automatic test_two_req();
        do_reset();
        req_ren[0] = 1'b1;
        req_ren[3] = 1'b1;
        req_wen[3] = 1'b1;
        run(8, 0);
        checks++; if (acc_q.size() != 2) $display("FAIL two_count got %0d exp 2", acc_q.size()); else passed++;
        checks++; if (acc_q[0] != 0) $display("FAIL two_first got %0d exp 0", acc_q[0]); else passed++;
        checks++; if (acc_q[1] != 3) $display("FAIL two_second got %0d exp 3", acc_q[1]); else passed++;
        checks++; if (rw_q[1] !== 2'b01) $display("FAIL two_write_wins got %b exp 01", rw_q[1]); else passed++;
        acc_q.delete();
        req_ren[0] = 1'b1;
        req_ren[2] = 1'b1;
        run(10, 1);
        checks++; if (acc_q.size() != 2) $display("FAIL wrap_count got %0d exp 2", acc_q.size()); else passed++;
        checks++; if (acc_q[0] != 0) $display("FAIL wrap_first got %0d exp 0", acc_q[0]); else passed++;
        checks++; if (acc_q[1] != 2) $display("FAIL wrap_second got %0d exp 2", acc_q[1]); else passed++;
    endtask

    task automatic test_all_rr();
        do_reset();
        keep    = 4'b1111;
        req_ren = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_addr[i] = $urandom;
        run(60, 1);
        checks++; if (acc_q.size() < 12) $display("FAIL rr_count got %0d exp >=12", acc_q.size()); else passed++;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (acc_q[k] != k % NREQ) $display("FAIL rr_order[%0d] got %0d exp %0d", k, acc_q[k], k % NREQ);
            else passed++;
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_wen[1]   = 1'b1;
        req_lock[1]  = 1'b1;
        req_store[1] = $urandom;
        tick();
        checks++; if (grant !== 4'b0010) $display("FAIL lock_grant got %b exp 0010", grant); else passed++;
        req_ren[0] = 1'b1;
        keep       = 4'b0010;
        run(20, 0);
        checks++; if (acc_q.size() < 9) $display("FAIL lock_count got %0d exp >=9", acc_q.size()); else passed++;
        for (int k = 0; k < MAXLOCK; k++) begin
            checks++;
            if (acc_q[k] != 1) $display("FAIL lock_owner[%0d] got %0d exp 1", k, acc_q[k]);
            else passed++;
        end
        checks++; if (acc_q[MAXLOCK] != 0) $display("FAIL lock_next got %0d exp 0", acc_q[MAXLOCK]); else passed++;
        checks++; if (cyc_q[MAXLOCK-1] - cyc_q[0] != MAXLOCK - 1) $display("FAIL lock_nobubble got %0d exp %0d", cyc_q[MAXLOCK-1] - cyc_q[0], MAXLOCK - 1); else passed++;
        checks++; if (cyc_q[MAXLOCK] - cyc_q[MAXLOCK-1] != 2) $display("FAIL lock_release_gap got %0d exp 2", cyc_q[MAXLOCK] - cyc_q[MAXLOCK-1]); else passed++;
        checks++; if (rw_q[0] !== 2'b01) $display("FAIL lock_wen got %b exp 01", rw_q[0]); else passed++;
    endtask

    task automatic test_error();
        do_reset();
        req_ren[1] = 1'b1;
        req_ren[2] = 1'b1;
        tick();
        checks++; if (grant !== 4'b0010) $display("FAIL err_grant got %b exp 0010", grant); else passed++;
        ramstate   = ERROR;
        req_ren[0] = 1'b1;
        #1;
        checks++; if (err !== 1'b1) $display("FAIL err_pulse got %b exp 1", err); else passed++;
        checks++; if (req_wait !== 4'b1111) $display("FAIL err_wait got %b exp 1111", req_wait); else passed++;
        tick();
        ramstate = FREE;
        #1;
        checks++; if (err !== 1'b0) $display("FAIL err_clear got %b exp 0", err); else passed++;
        checks++; if (grant !== 4'b0000) $display("FAIL err_arb got %b exp 0000", grant); else passed++;
        tick();
        checks++; if (grant !== 4'b0100) $display("FAIL err_next got %b exp 0100", grant); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_ren[1]  = 1'b1;
        req_addr[1] = 32'h1234;
        ramload     = 32'hA5A5_5A5A;
        tick();
        ramstate = BUSY;
        #1;
        checks++; if ({grant, ramREN} !== 5'b00101) $display("FAIL arst_pre got %b exp 00101", {grant, ramREN}); else passed++;
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) $display("FAIL arst_grant got %b exp 0000", grant); else passed++;
        checks++; if (req_wait !== 4'b1111) $display("FAIL arst_wait got %b exp 1111", req_wait); else passed++;
        checks++; if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'h0) $display("FAIL arst_bus got %h exp 0", {ramREN, ramWEN, ramaddr, ramstore}); else passed++;
        checks++; if ({req_load, err} !== '0) $display("FAIL arst_load got %h exp 0", {req_load, err}); else passed++;
        req_ren  = 4'b0101;
        ramstate = FREE;
        tick();
        nRST = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000) $display("FAIL arst_release got %b exp 0000", grant); else passed++;
        tick();
        checks++; if (grant !== 4'b0001) $display("FAIL arst_first got %b exp 0001", grant); else passed++;
    endtask

    task automatic test_random(input int ncycles);
        logic [3:0]       pend, done_prev, prev_grant, r, ex_grant, ex_wait;
        logic [3:0][31:0] ex_load;
        logic             ex_ren, ex_wen, ex_err, active;
        logic [31:0]      ex_addr, ex_store;
        int               m_owner, m_ptr, m_burst, rs, rw, g;
        int               skip[4];
        do_reset();
        m_owner = -1;
        m_ptr = 0;
        m_burst = 0;
        pend = '0;
        done_prev = '0;
        prev_grant = '0;
        for (int i = 0; i < NREQ; i++) skip[i] = 0;
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] || done_prev[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rw           = $urandom_range(1, 3);
                        pend[i]      = 1'b1;
                        req_ren[i]   = rw[0];
                        req_wen[i]   = rw[1];
                        req_addr[i]  = $urandom;
                        req_store[i] = $urandom;
                    end else begin
                        pend[i]    = 1'b0;
                        req_ren[i] = 1'b0;
                        req_wen[i] = 1'b0;
                        skip[i]    = 0;
                    end
                end else if (m_owner == i && $urandom_range(0, 15) == 0) begin
                    pend[i]    = 1'b0;
                    req_ren[i] = 1'b0;
                    req_wen[i] = 1'b0;
                    skip[i]    = 0;
                end
                req_lock[i] = 1'($urandom_range(0, 1));
            end
            rs = $urandom_range(0, 19);
            if (rs < 2) ramstate = FREE;
            else if (rs < 9) ramstate = BUSY;
            else if (rs < 19) ramstate = ACCESS;
            else ramstate = ERROR;
            ramload = $urandom;
            #1;
            r        = req_ren | req_wen;
            active   = (m_owner >= 0) && r[m_owner];
            ex_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            ex_wen   = active && req_wen[m_owner];
            ex_ren   = active && req_ren[m_owner] && !req_wen[m_owner];
            ex_addr  = active ? req_addr[m_owner] : 32'h0;
            ex_store = active ? req_store[m_owner] : 32'h0;
            ex_err   = active && (ramstate == ERROR);
            ex_wait  = 4'b1111;
            ex_load  = '0;
            if (m_owner >= 0) ex_load[m_owner] = ramload;
            if (active && ramstate == ACCESS) ex_wait[m_owner] = 1'b0;
            checks++; if (grant !== ex_grant) $display("FAIL rnd_grant cyc %0d got %b exp %b", cyc, grant, ex_grant); else passed++;
            checks++; if (req_wait !== ex_wait) $display("FAIL rnd_wait cyc %0d got %b exp %b", cyc, req_wait, ex_wait); else passed++;
            checks++; if ({ramREN, ramWEN, ramaddr, ramstore} !== {ex_ren, ex_wen, ex_addr, ex_store})
                $display("FAIL rnd_bus cyc %0d got %h exp %h", cyc, {ramREN, ramWEN, ramaddr, ramstore}, {ex_ren, ex_wen, ex_addr, ex_store});
            else passed++;
            checks++; if (req_load !== ex_load) $display("FAIL rnd_load cyc %0d got %h exp %h", cyc, req_load, ex_load); else passed++;
            checks++; if (err !== ex_err) $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, err, ex_err); else passed++;
            if (grant != 4'b0000 && prev_grant == 4'b0000) begin
                g = idx_of(grant);
                for (int i = 0; i < NREQ; i++) begin
                    if (i == g) begin
                        skip[i] = 0;
                    end else if (pend[i]) begin
                        skip[i]++;
                        checks++;
                        if (skip[i] > NREQ - 1) $display("FAIL rnd_fair port %0d got %0d exp <=%0d", i, skip[i], NREQ - 1);
                        else passed++;
                    end
                end
            end
            prev_grant = grant;
            done_prev  = ~ex_wait;
            if (m_owner < 0) begin
                if (r != 4'b0000) begin
                    m_owner = rr_pick(m_ptr, r);
                    m_burst = 1;
                end
            end else if (!active || ramstate == ERROR) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else if (ramstate == ACCESS) begin
                if (req_lock[m_owner] && m_burst < MAXLOCK) begin
                    m_burst++;
                end else begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_two_req();
        test_all_rr();
        test_lock();
        test_error();
        test_async_reset();
        test_random(400);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- N-way round-robin arbiter that shares the single-ported RAM among requesters, such as per-core icache/dcache ports or DMA.
- Sits between the cache/coherence side and the RAM, and drives ramREN/ramWEN/ramaddr/ramstore.
- Provides per-requester wait/load handshakes with bounded burst locking.
- Guarantees starvation freedom.

Parameters:
NREQ, 4, number of requesters (>=2); index width IW = $clog2(NREQ)
MAXLOCK, 8, max consecutive RAM accesses one owner may hold via lock (>=1)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
req_ren  in  NREQ  per-requester read request
req_wen  in  NREQ  per-requester write request
req_lock  in  NREQ  owner requests to keep grant after current access completes
req_addr  in  NREQ x 32  per-requester word address
req_store  in  NREQ x 32  per-requester write data
req_wait  out  NREQ  1 = stall; 0 for one cycle = access done
req_load  out  NREQ x 32  read data; valid when req_wait low
grant  out  NREQ  one-hot current owner, 0 when none
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from cpu_types_pkg
err  out  1  one-cycle pulse on RAM ERROR

Behaviour:
- Reset (async, nRST=0): state=ARB, ptr=0, owner=0, lockcnt=0.
- Reset output values: grant=0, req_wait=all 1, req_load=0, ramREN=ramWEN=0, ramaddr=ramstore=0, err=0.
- req_i = req_ren[i] | req_wen[i]. If both are high, the write wins: ramWEN=1, ramREN=0.
- States: ARB, OWN.
- ARB:
  - RAM outputs are 0, all req_wait=1, grant=0.
  - If any req_i, owner <= first i with req_i scanning ptr, ptr+1, ... mod NREQ; lockcnt <= 0; next state OWN.
  - Otherwise stay in ARB.
  - Arbitration is registered, so there is a 1-cycle ARB bubble between grants.
- OWN:
  - grant[owner]=1.
  - ramREN/ramWEN/ramaddr/ramstore driven combinationally from owner inputs.
  - req_wait[owner] = (ramstate != ACCESS); req_load[owner] = ramload; non-owners wait=1, load=0.
- OWN transitions:
  - ramstate==ACCESS and req_lock[owner] and lockcnt < MAXLOCK-1: stay OWN, lockcnt++.
  - ramstate==ACCESS otherwise: ptr <= owner+1 (wrap at NREQ), next ARB.
  - req_i of owner drops before ACCESS (abort): RAM enables go 0 the same cycle; ptr <= owner+1; next ARB. No wait-low pulse.
  - ramstate==ERROR: err=1 this cycle, req_wait[owner] stays 1, ptr <= owner+1, next ARB.
  - FREE/BUSY: stay OWN.
- Lock is sampled only in the ACCESS cycle. Dropping the lock between accesses releases the owner at the next ACCESS.
- Fairness: a continuously requesting port is granted within NREQ-1 intervening grants, each at most MAXLOCK accesses.
- Requests from non-owners never affect RAM outputs.
- Address/data must be held stable by the owner until its wait drops. The arbiter does not latch them.
- Port inputs must not be X while asserted. No other protocol checks are performed.

Test Plan:
1. Reset, then req_ren[2]=1, addr=0x40, RAM returns BUSY,BUSY,ACCESS with ramload=0xDEADBEEF:
   - grant=4'b0100 one cycle after request.
   - ramREN=1, ramaddr=0x40.
   - req_wait[2] low only in the ACCESS cycle, with req_load[2]=0xDEADBEEF.
   - ARB follows, ptr=3.
2. req_ren[0] and req_wen[3] asserted together from reset, 1-cycle ACCESS each:
   - Service order is 0 then 3.
   - ptr wraps to 0 after 3 completes.
3. All four requesters hold requests for 12 accesses:
   - Grant order is 0,1,2,3,0,1,2,3,...
   - No port is granted twice before every other port is granted once.
4. req_wen[1] with req_lock[1] held high, MAXLOCK=8, while req_ren[0] is pending:
   - Port 1 is granted exactly 8 consecutive ACCESS cycles without an ARB bubble.
   - ARB follows, then port 0 is granted.
5. Owner 1 gets ramstate=ERROR:
   - err pulses 1 cycle.
   - req_wait[1] never drops.
   - Next grant goes to the next requester after 1.
6. nRST asserted mid-OWN while RAM is BUSY:
   - All outputs reach reset values immediately (async).
   - After release, port 0 is granted first given simultaneous requests on 0 and 2.
